uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that serialises one 8-bit byte per frame onto a single idle-high line.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit period is CLKS_PER_BIT clocks. The default of 16 matches the team's uart_rx, which re-arms on the line's low level and samples every 16 clocks. uart_tx output can drive uart_rx rs232 input directly for loopback.
- Sits between the byte-producing logic and the serial pin, with a valid/ready byte handshake.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; legal range >= 2; bit counter width is $clog2(CLKS_PER_BIT).
- DATA_BITS, 8, data bits per frame; fixed at 8 for this release; the counter is sized from it.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send; sampled only on an accept cycle
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  block can accept a byte (high only in IDLE)
- tx  output  1  serial line, registered, idle high
- busy  output  1  frame in progress (high from the cycle after accept until the frame completes)
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, busy=0, done=0, tx_ready=1, state=IDLE, counters=0.
  - A partial frame is abandoned; the line returns high immediately.
- Accept: at a rising edge where tx_valid=1 and tx_ready=1.
  - Latch tx_data into the shift register.
  - Go to START.
  - busy becomes 1 and tx becomes 0 after that same edge.
- tx_valid while busy=1 is ignored. There is no queue and the byte is not latched; the producer must hold valid until ready.
- States:
  - IDLE: tx=1. tx_ready=~busy (combinational from state, 1 in IDLE). On accept, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the edge ending the stop bit, go to IDLE with busy<=0 and done<=1.
- done is high for exactly one cycle: the first IDLE cycle. It is cleared the next cycle regardless of inputs.
- Back-to-back frames: tx_valid may be accepted in the same cycle done=1.
  - Minimum frame-to-frame spacing is 10*CLKS_PER_BIT+1 clocks (one idle-high cycle between stop and next start).
- Timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - No drift: each bit lasts exactly CLKS_PER_BIT cycles.
  - done rises 10*CLKS_PER_BIT cycles after the accepting edge.
- tx is a flop output and glitch-free; it only changes at bit boundaries.
- Changes to tx_data after accept have no effect on the current frame.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11 bits. done rises 11*CLKS_PER_BIT cycles after accept.
- When undefined: no PARITY state, no parity logic, 10-bit frame as above.
- Note: uart_rx does not check parity, so loopback tests against it run with the macro undefined.

Test Plan:
- Reset then idle, no tx_valid for 100 cycles -> tx=1, busy=0, done=0, tx_ready=1 throughout.
- Send 0x55 with CLKS_PER_BIT=16 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held exactly 16 cycles; done single pulse 160 cycles after accept; busy falls the same edge.
- Loopback into uart_rx, send 0xA3 then 0x0F back-to-back (tx_valid held high) -> uart_rx rx_data=0xA3 then 0x0F; uart_tx done pulses 161 cycles apart.
- Pulse tx_valid with tx_data=0xFF during an in-progress 0x00 frame -> ignored; line carries 0x00 only; tx_ready=0 during the frame.
- Assert rst_n=0 in the middle of data bit 3 -> tx=1 asynchronously, busy=0, no done pulse. After release a new byte 0x81 transmits correctly.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit=1; send 0x03 -> parity bit=0; done 176 cycles after accept (CLKS_PER_BIT=16).

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d is the value the line takes after the next edge, so tx only moves at bit boundaries.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d  = S_START;
          shift_d  = tx_data;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line-decoding scoreboard.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, done;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         mon_frames = 0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line receiver: samples mid-bit and checks each frame against the scoreboard.
  logic       mon_active = 1'b0;
  int         mon_k = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_par = 1'b0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_k      <= 1;
      end
    end else begin
      mon_k <= mon_k + 1;
      if (mon_k == CPB / 2) check("mon_start_bit", {31'd0, tx}, 32'd0);
      if (mon_k >= CPB && mon_k < 9 * CPB && (mon_k % CPB) == CPB / 2)
        mon_byte[mon_k / CPB - 1] <= tx;
`ifdef UART_TX_PARITY_EN
      if (mon_k == 9 * CPB + CPB / 2) mon_par <= tx;
`endif
      if (mon_k == (FL - 1) * CPB + CPB / 2) begin
        check("mon_stop_bit", {31'd0, tx}, 32'd1);
        mon_frames <= mon_frames + 1;
        if (sb.size() == 0) begin
          check("mon_unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb.pop_front();
          check("mon_rx_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
`ifdef UART_TX_PARITY_EN
          check("mon_parity", {31'd0, mon_par}, {31'd0, ^mon_exp});
`endif
        end
        mon_active <= 1'b0;
      end
    end
  end

  // Drives one byte, checks every cycle of the frame, then the done cycle.
  task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic p,
                      input bit intrude, output int done_at);
    logic [10:0] e;
    int bad[11];
    int ready_hi, busy_lo, done_hi, guard;
`ifdef UART_TX_PARITY_EN
    e = {1'b1, p, fr[8:0]};
`else
    e = {1'b0, fr};
`endif
    for (int b = 0; b < 11; b++) bad[b] = 0;
    ready_hi = 0; busy_lo = 0; done_hi = 0; guard = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 4 * FL * CPB) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(d);
    for (int k = 0; k < FL * CPB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_valid = 1'b0;
        tx_data  = ~d;
      end
      if (intrude && k == 40) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (intrude && k == 70) tx_valid = 1'b0;
      if (tx !== e[k / CPB]) bad[k / CPB]++;
      if (tx_ready !== 1'b0) ready_hi++;
      if (busy !== 1'b1) busy_lo++;
      if (done !== 1'b0) done_hi++;
    end
    for (int b = 0; b < FL; b++)
      check($sformatf("frame_%02h_bit%0d_bad_cycles", d, b), bad[b], 0);
    check("ready_low_in_frame", ready_hi, 0);
    check("busy_high_in_frame", busy_lo, 0);
    check("no_early_done", done_hi, 0);
    @(negedge clk);
    check("done_at_frame_end", {31'd0, done}, 32'd1);
    check("busy_falls_with_done", {31'd0, busy}, 32'd0);
    check("tx_idle_after_frame", {31'd0, tx}, 32'd1);
    check("ready_after_frame", {31'd0, tx_ready}, 32'd1);
    done_at = cyc;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[6];
  int   done_cyc[6];
  int   t_dummy;
  int   idle_bad;

  initial begin
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 10'h346, 1'b0};
    vecs[2] = '{8'h0F, 10'h21E, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h07, 10'h20E, 1'b1};
    vecs[5] = '{8'h03, 10'h206, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    rst_n = 1'b1;

    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) idle_bad++;
    end
    check("idle_100_bad_cycles", idle_bad, 0);

    // Table vectors run back to back: each accept lands on the done cycle of the previous frame.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].frame, vecs[i].par, 1'b0, done_cyc[i]);
      if (i > 0) check($sformatf("done_gap_%0d", i), done_cyc[i] - done_cyc[i-1], FL * CPB + 1);
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    repeat (5) @(negedge clk);
    send(8'h00, 10'h200, 1'b0, 1'b1, t_dummy);

    // Reset in the middle of data bit 3 of 0xF0 (bit 3 is 0, so tx must jump high).
    repeat (5) @(negedge clk);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    @(posedge clk);
    sb.push_back(8'hF0);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * CPB + 6) @(negedge clk);
    check("pre_rst_tx_bit3", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("async_rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < FL * CPB + 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) idle_bad++;
    end
    check("no_done_after_abort", idle_bad, 0);
    send(8'h81, 10'h302, 1'b0, 1'b0, t_dummy);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("frames_received", mon_frames, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
